// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// IMEM_LOADER_CHECKSUM_EN adds the CHECK state to the state type.
package imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
  localparam int         BYTES_PER_WORD = 4;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_RUN,
    S_ERROR,
    S_CHECK
  } imem_loader_state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_RUN,
    S_ERROR
  } imem_loader_state_t;
`endif

  function automatic logic is_busy(
    imem_loader_state_t s
  );
    return !(s == S_IDLE ||
             s == S_RUN  ||
             s == S_ERROR);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Instruction-memory write/address port driven by the loader.
// Master drives address, data and write enable; memory is the slave.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int INST_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] imem_addr_out;
  logic [INST_WIDTH-1:0] imem_wdata_out;
  logic                  imem_we_out;

  modport master (
    output imem_addr_out,
    output imem_wdata_out,
    output imem_we_out
  );

  modport slave (
    input imem_addr_out,
    input imem_wdata_out,
    input imem_we_out
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs a byte stream into little-endian 32-bit words.
// word and word_valid are registered; last flags the 4th lane.
module word_assembler
  import imem_loader_pkg::*;
#(
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  strobe,
  input  logic [7:0]            data,
  output logic                  last,
  output logic [INST_WIDTH-1:0] word,
  output logic                  word_valid
);

  localparam logic [1:0] LAST_IDX =
    2'(BYTES_PER_WORD - 1);

  logic [1:0]  idx;
  logic [23:0] part;

  assign last = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx        <= '0;
      part       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      idx        <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (strobe) begin
        if (last) begin
          word       <= INST_WIDTH'({data, part});
          word_valid <= 1'b1;
          idx        <= '0;
        end else begin
          unique case (idx)
            2'd0:    part[7:0]   <= data;
            2'd1:    part[15:8]  <= data;
            default: part[23:16] <= data;
          endcase
          idx <= idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: UART bytes -> instruction memory, then hands port to PC.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing sum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = 6,
  parameter int         INST_WIDTH = 32,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data_in,
  input  logic                  rx_valid_in,
  input  logic                  reload_in,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_in,
  imem_loader_if.master         imem,
  output logic                  cpu_run_out,
  output logic                  busy_out,
  output logic                  error_out
);

  localparam int CW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  imem_loader_state_t state, state_n;

  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  clear;
  logic                  strobe;
  logic                  last;
  logic                  last_word;

  logic                  run_q;
  logic                  busy_q;
  logic                  err_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum, sum_n;
`endif

  word_assembler #(
    .INST_WIDTH (INST_WIDTH)
  ) u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .strobe     (strobe),
    .data       (rx_data_in),
    .last       (last),
    .word       (imem.imem_wdata_out),
    .word_valid (imem.imem_we_out)
  );

  assign last_word = (cnt == CW'(1));

  always_comb begin
    state_n = state;
    addr_n  = addr;
    cnt_n   = cnt;
    clear   = 1'b0;
    strobe  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_n   = sum;
`endif
    if (reload_in) begin
      state_n = S_IDLE;
      clear   = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (rx_valid_in &&
              rx_data_in == SYNC_BYTE)
            state_n = S_COUNT;
        end
        S_COUNT: begin
          if (rx_valid_in) begin
            if (rx_data_in == 8'd0) begin
              state_n = S_RUN;
            end else if (int'(rx_data_in) > DEPTH) begin
              state_n = S_ERROR;
            end else begin
              addr_n  = '0;
              cnt_n   = CW'(rx_data_in);
              clear   = 1'b1;
              state_n = S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
              sum_n   = 8'd0;
`endif
            end
          end
        end
        S_DATA: begin
          if (rx_valid_in) begin
            strobe = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_n  = sum + rx_data_in;
`endif
            if (last)
              state_n = S_WRITE;
          end
        end
        S_WRITE: begin
          addr_n = addr + ADDR_WIDTH'(1);
          cnt_n  = cnt - CW'(1);
          if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            // A byte landing in the final write is the checksum.
            if (!rx_valid_in)
              state_n = S_CHECK;
            else if (rx_data_in == sum)
              state_n = S_RUN;
            else
              state_n = S_ERROR;
`else
            state_n = S_RUN;
`endif
          end else begin
            state_n = S_DATA;
            if (rx_valid_in) begin
              strobe = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
              sum_n  = sum + rx_data_in;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (rx_valid_in)
            state_n = (rx_data_in == sum) ?
                      S_RUN : S_ERROR;
        end
`endif
        S_RUN:   state_n = S_RUN;
        S_ERROR: state_n = S_ERROR;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      addr   <= '0;
      cnt    <= '0;
      run_q  <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      addr   <= addr_n;
      cnt    <= cnt_n;
      run_q  <= (state_n == S_RUN);
      busy_q <= is_busy(state_n);
      err_q  <= (state_n == S_ERROR);
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      sum <= 8'd0;
    else
      sum <= sum_n;
  end
`endif

  assign imem.imem_addr_out =
    (state == S_RUN) ? cpu_addr_in : addr;

  assign cpu_run_out = run_q;
  assign busy_out    = busy_q;
  assign error_out   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (default build).
// Writes are logged at the falling edge; checks run 1 ns after rising edges.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       reload;
  logic [5:0] cpu_addr;
  logic       cpu_run;
  logic       busy;
  logic       error;

  int checks = 0;
  int errors = 0;
  int nwr    = 0;

  imem_loader_if #(.ADDR_WIDTH(6), .INST_WIDTH(32)) imem ();

  imem_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data_in  (rx_data),
    .rx_valid_in (rx_valid),
    .reload_in   (reload),
    .cpu_addr_in (cpu_addr),
    .imem        (imem),
    .cpu_run_out (cpu_run),
    .busy_out    (busy),
    .error_out   (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (imem.imem_we_out === 1'b1)
      nwr++;

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic chk_write(string tag,
                           logic [5:0] a,
                           logic [31:0] d);
    chk({tag, "_we"}, 32'(imem.imem_we_out), 32'd1);
    chk({tag, "_addr"}, 32'(imem.imem_addr_out), 32'(a));
    chk({tag, "_wdata"}, imem.imem_wdata_out, d);
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    reload   = 1'b0;
    cpu_addr = 6'h00;
    tick(); tick(); tick();

    chk("rst_addr", 32'(imem.imem_addr_out), 32'd0);
    chk("rst_wdata", imem.imem_wdata_out, 32'd0);
    chk("rst_we", 32'(imem.imem_we_out), 32'd0);
    chk("rst_run", 32'(cpu_run), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    rst_n = 1'b1;

    // two-word image
    send(8'hA5);
    chk("t1_busy", 32'(busy), 32'd1);
    send(8'h02);
    send(8'h13); send(8'h32); send(8'h00);
    send(8'h8B);
    chk_write("t1_w0", 6'h00, 32'h8B003213);
    send(8'h01);
    chk("t1_we_gap", 32'(imem.imem_we_out), 32'd0);
    send(8'h00); send(8'h00);
    chk("t1_run_pre", 32'(cpu_run), 32'd0);
    send(8'h91);
    chk_write("t1_w1", 6'h01, 32'h91000001);
    chk("t1_run_wr", 32'(cpu_run), 32'd0);
    tick();
    chk("t1_run", 32'(cpu_run), 32'd1);
    chk("t1_busy_run", 32'(busy), 32'd0);
    chk("t1_nwr", 32'(nwr), 32'd2);
    cpu_addr = 6'h2A;
    #1;
    chk("mux_addr", 32'(imem.imem_addr_out), 32'h2A);
    chk("mux_we", 32'(imem.imem_we_out), 32'd0);
    send(8'hA5);
    chk("run_ign_run", 32'(cpu_run), 32'd1);
    chk("run_ign_busy", 32'(busy), 32'd0);

    // oversize count
    pulse_reload();
    chk("rl_run", 32'(cpu_run), 32'd0);
    send(8'hA5);
    send(8'h41);
    chk("t2_err", 32'(error), 32'd1);
    chk("t2_run", 32'(cpu_run), 32'd0);
    chk("t2_busy", 32'(busy), 32'd0);
    tick();
    chk("t2_err_hold", 32'(error), 32'd1);
    chk("t2_nwr", 32'(nwr), 32'd2);
    pulse_reload();
    chk("t2_err_clr", 32'(error), 32'd0);
    chk("t2_busy_idle", 32'(busy), 32'd0);

    // sync byte coincident with reload is dropped
    reload   = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    tick();
    reload   = 1'b0;
    rx_valid = 1'b0;
    send(8'h01);
    chk("rl_sync_drop", 32'(busy), 32'd0);

    // back-to-back bytes, sync in the write cycle
    send(8'hA5); send(8'h01);
    send(8'h11); send(8'h22); send(8'h33);
    send(8'h44);
    chk_write("t3_w", 6'h00, 32'h44332211);
    send(8'hA5);
    chk("t3_run", 32'(cpu_run), 32'd1);
    chk("t3_we", 32'(imem.imem_we_out), 32'd0);
    tick();
    chk("t3_nwr", 32'(nwr), 32'd3);
    chk("t3_busy", 32'(busy), 32'd0);

    // reload mid-word
    pulse_reload();
    send(8'hA5); send(8'h01);
    send(8'hAA); send(8'hBB);
    pulse_reload();
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_run", 32'(cpu_run), 32'd0);
    tick(); tick();
    chk("t4_nwr", 32'(nwr), 32'd3);
    chk("t4_run2", 32'(cpu_run), 32'd0);
    send(8'hA5); send(8'h01);
    send(8'hAA); send(8'hBB); send(8'hCC);
    send(8'hDD);
    chk_write("t4_w", 6'h00, 32'hDDCCBBAA);
    tick();
    chk("t4_run3", 32'(cpu_run), 32'd1);

    // empty image keeps memory
    pulse_reload();
    send(8'hA5);
    send(8'h00);
    chk("n0_run", 32'(cpu_run), 32'd1);
    chk("n0_busy", 32'(busy), 32'd0);
    tick();
    chk("n0_nwr", 32'(nwr), 32'd4);

    // full-depth image
    pulse_reload();
    send(8'hA5);
    send(8'h40);
    for (int i = 0; i < 256; i++)
      send(8'(i));
    chk_write("full_last", 6'h3F, 32'hFFFEFDFC);
    tick();
    chk("full_run", 32'(cpu_run), 32'd1);
    chk("full_nwr", 32'(nwr), 32'd68);

    // reset mid-load
    pulse_reload();
    send(8'hA5); send(8'h02);
    send(8'h11); send(8'h22); send(8'h33);
    rx_data  = 8'h44;
    rx_valid = 1'b1;
    rst_n    = 1'b0;
    tick();
    rx_valid = 1'b0;
    chk("mr_we", 32'(imem.imem_we_out), 32'd0);
    chk("mr_wdata", imem.imem_wdata_out, 32'd0);
    chk("mr_addr", 32'(imem.imem_addr_out), 32'd0);
    chk("mr_run", 32'(cpu_run), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_err", 32'(error), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mr_nwr", 32'(nwr), 32'd68);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time controller for the instruction memory in the multicycle LEGv8 UART system. It receives an image over the UART byte stream and assembles little-endian 32-bit words. It sequences those words into instruction memory through its single address/write port, and holds the CPU stalled until the load completes. After the load it hands the memory address port to the CPU's PC, so the loader and the CPU share one memory port.

## Interface
Parameters:
- ADDR_WIDTH, 6, instruction memory word-address width (depth = 2^ADDR_WIDTH)
- INST_WIDTH, 32, instruction width; fixed at 4 bytes, other values unsupported
- SYNC_BYTE, 8'hA5, byte that starts a load

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, synchronous, active-low
- rx_data_in  in  8  received UART byte
- rx_valid_in  in  1  one-cycle strobe, rx_data_in valid; no backpressure
- reload_in  in  1  one-cycle request to abandon the current run/load and wait for a new image
- cpu_addr_in  in  ADDR_WIDTH  CPU instruction word address (PC)
- imem_addr_out  out  ADDR_WIDTH  address to instruction memory
- imem_wdata_out  out  INST_WIDTH  write data to instruction memory
- imem_we_out  out  1  write enable to instruction memory
- cpu_run_out  out  1  CPU may advance; 0 stalls the CPU
- busy_out  out  1  load in progress (any state except IDLE, RUN, ERROR)
- error_out  out  1  load failed

## Operation
- States: IDLE, COUNT, DATA, WRITE, RUN, ERROR; CHECK only when the configuration macro below is defined.
- IDLE: a byte equal to SYNC_BYTE goes to COUNT. Any other byte is ignored.
- COUNT: the next byte is N, the number of words.
  - N = 0 goes to RUN, keeping the existing memory contents.
  - N > 2^ADDR_WIDTH goes to ERROR.
  - Otherwise: word address cleared to 0, word counter = N, byte index = 0, go to DATA.
- DATA: each byte is stored at byte lane (byte index); lane 0 = bits [7:0]. When the 4th byte arrives, go to WRITE.
- WRITE lasts one cycle. It asserts imem_we_out with the assembled word at the current word address, then increments the address and decrements the counter.
  - Counter reaching 0 goes to RUN (or to CHECK when the macro is defined).
  - Otherwise go to DATA.
  - A byte arriving in the WRITE cycle is captured as lane 0 of the next word. No byte is ever dropped.
- RUN: cpu_run_out = 1 and imem_addr_out follows cpu_addr_in. Bytes are ignored in RUN.
- ERROR: error_out = 1 and cpu_run_out = 0. Left only by reset or reload_in.
- reload_in, in any state: go to IDLE and clear error.
  - A simultaneous rx_valid_in byte is dropped, including a SYNC_BYTE.
- Address mux: imem_addr_out = cpu_addr_in in RUN, otherwise the loader word address. imem_we_out is never asserted in RUN.
- The word address wraps modulo 2^ADDR_WIDTH. With N = 2^ADDR_WIDTH, the last write goes to the top address and no wrap is ever written.

## Timing
- Reset values (all outputs): state IDLE, imem_addr_out = 0, imem_wdata_out = 0, imem_we_out = 0, cpu_run_out = 0, busy_out = 0, error_out = 0.
- Reset asserted mid-load aborts with no further write. Memory contents are not cleared.
- imem_we_out and imem_wdata_out are registered. The write strobe occurs exactly 1 cycle after the clock edge that accepts the 4th byte of a word.
- cpu_run_out, busy_out and error_out are registered and reflect the state entered on the previous edge. cpu_run_out rises the cycle after the last WRITE (no checksum).
- The imem_addr_out mux is combinational from the registered state and cpu_addr_in.
- cpu_run_out falls the cycle after reload_in.
- No minimum byte spacing: back-to-back rx_valid_in on every cycle must be handled.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last WRITE, the state goes to CHECK.
  - The next byte is compared with the 8-bit modulo sum of all 4*N data bytes.
  - Match goes to RUN; mismatch goes to ERROR.
  - For N = 0, no checksum byte is expected.
- Undefined: the CHECK state and the sum register do not exist, and the last WRITE goes directly to RUN.

## Structure
- Package imem_loader_pkg holds:
  - the state enum type imem_loader_state_t
  - the default SYNC_BYTE constant
  - the BYTES_PER_WORD = 4 constant
- Sub-module word_assembler:
  - takes byte strobes and outputs a 32-bit word plus a word_valid pulse
  - has a clear input
- The top level holds the FSM, address/count registers, the optional checksum and the address mux.

## Test plan
- Reset, then A5, 02, bytes 13 32 00 8B 01 00 00 91 → writes 8B003213 at address 0 and 91000001 at address 1. cpu_run_out = 1 one cycle after the second write.
- A5 then N = 0x41 with ADDR_WIDTH = 6 → error_out = 1, no write. reload_in → error_out = 0, state IDLE.
- Bytes on every cycle: A5, 01, 11 22 33 44, then A5 in the WRITE cycle → single write 44332211; trailing byte ignored in RUN.
- Mid-load reload_in after 2 data bytes → no write, cpu_run_out stays 0. A new A5 01 AA BB CC DD → writes DDCCBBAA at address 0.
- In RUN, drive cpu_addr_in = 0x2A → imem_addr_out = 0x2A, imem_we_out = 0. Assert rst_n = 0 mid-load → all outputs at reset values next cycle.
- With IMEM_LOADER_CHECKSUM_EN: A5 01 01 02 03 04 then 0A → RUN. Then reload_in, A5 01 01 02 03 04, then 0B → ERROR.
